cla_sub_seq: RTL and testbench

Multi-cycle, multi-precision subtractor: computes D = A − B − BI on WIDTH-bit operands, one 4-bit nibble per clock, through a single 4-bit carry-lookahead stage fed with inverted B. It is the subtract path that pairs with the team's 4-bit CLA adder. It sits behind a start/done handshake so a controller can issue wide subtractions without a full-width combinational borrow chain.

---
 rtl/cla_sub_seq.sv | 127 ++++++++++++
 tb/tb_cla_sub_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cla_sub_seq.sv
// Multi-cycle WIDTH-bit subtractor D = A - B - BI, one nibble per clock
// through a single 4-bit carry-lookahead stage fed with inverted B.
module cla_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] D,
  output logic             BO,
  output logic             V,
  output logic             Z
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;

  logic [3:0]       nib_a_s;
  logic [3:0]       nib_b_s;
  logic [4:0]       sum_s;
  logic [WIDTH-1:0] work_next_s;

  // 4-bit lookahead add: every carry is a flat sum of products of p/g/c0,
  // so no carry ripples through the previous bit. Returns {c4, sum}.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] bn,
                                      input logic c0);
    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    p  = a ^ bn;
    g  = a & bn;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ {c3, c2, c1, c0}};
  endfunction

  // Current nibble step and the working result with that nibble replaced
  always_comb begin
    nib_a_s     = a_r[{cnt_r, 2'b00} +: 4];
    nib_b_s     = b_r[{cnt_r, 2'b00} +: 4];
    sum_s       = cla4(nib_a_s, ~nib_b_s, carry_r);
    work_next_s = work_r;
    work_next_s[{cnt_r, 2'b00} +: 4] = sum_s[3:0];
  end

  // Control FSM, operand capture, nibble datapath and registered results
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      work_r  <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      D       <= '0;
      BO      <= 1'b0;
      V       <= 1'b0;
      Z       <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state_r)
        IDLE: begin
          if (START) begin
            a_r     <= A;
            b_r     <= B;
            // Subtraction as A + ~B + 1: a zero borrow-in is a carry-in of one
            carry_r <= ~BI;
            cnt_r   <= '0;
            work_r  <= '0;
            state_r <= RUN;
            BUSY    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          work_r  <= work_next_s;
          carry_r <= sum_s[4];
          if (cnt_r == LAST_NIB) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            D       <= work_next_s;
            BO      <= ~sum_s[4];
            Z       <= (work_next_s == '0);
            V       <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (work_next_s[WIDTH-1] ^ a_r[WIDTH-1]);
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_sub_seq.sv
// Randomised scoreboard bench for cla_sub_seq: an arithmetic reference model
// predicts results and completion edges; a negedge monitor compares.
module tb_cla_sub_seq;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int MAXE  = 8192;

  logic             CLK;
  logic             RST;
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BI;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] D;
  logic             BO;
  logic             V;
  logic             Z;

  typedef struct {
    int               done_edge;
    logic [WIDTH-1:0] d;
    logic             bo;
    logic             v;
    logic             z;
  } exp_t;

  exp_t             q[$];
  bit               exp_busy[0:MAXE-1];
  bit               rst_at[0:MAXE-1];
  int               cyc = 0;
  int               next_free = 0;
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] held_d = '0;
  logic             held_bo = 1'b0;
  logic             held_v = 1'b0;
  logic             held_z = 1'b0;

  cla_sub_seq #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BI(BI),
    .BUSY(BUSY), .DONE(DONE), .D(D), .BO(BO), .V(V), .Z(Z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the unsigned and signed views
  function automatic exp_t ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bi, input int done_edge);
    exp_t r;
    int   ud;
    int   sd;
    logic [31:0] tmp;
    ud = int'(a) - int'(b) - int'(bi);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bi);
    tmp = ud;
    r.done_edge = done_edge;
    r.d  = tmp[WIDTH-1:0];
    r.bo = (ud < 0);
    r.v  = (sd > 32767) || (sd < -32768);
    r.z  = (tmp[WIDTH-1:0] == '0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what the model predicts for it
  task automatic step(input logic rst, input logic st, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic bi);
    int e;
    e = cyc + 1;
    if (rst) begin
      rst_at[e] = 1'b1;
      for (int i = e; i < e + NIB + 2; i++) exp_busy[i] = 1'b0;
      while (q.size() > 0 && q[$].done_edge >= e) void'(q.pop_back());
      next_free = e + 1;
    end else if (st && e >= next_free) begin
      q.push_back(ref_sub(a, b, bi, e + NIB));
      for (int i = e; i < e + NIB; i++) exp_busy[i] = 1'b1;
      next_free = e + NIB + 1;
    end
    RST = rst; START = st; A = a; B = b; BI = bi;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
  endtask

  // Monitor: compare DUT outputs each cycle against the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (cyc > 0 && cyc < MAXE) begin
      if (rst_at[cyc]) begin
        held_d = '0; held_bo = 1'b0; held_v = 1'b0; held_z = 1'b0;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_d", 32'(D), 32'd0);
        chk("rst_flags", {29'd0, BO, V, Z}, 32'd0);
      end else begin
        chk("busy", 32'(BUSY), 32'(exp_busy[cyc]));
        if (q.size() > 0 && q[0].done_edge == cyc) begin
          e = q.pop_front();
          chk("done", 32'(DONE), 32'd1);
          chk("d", 32'(D), 32'(e.d));
          chk("bo", 32'(BO), 32'(e.bo));
          chk("v", 32'(V), 32'(e.v));
          chk("z", 32'(Z), 32'(e.z));
          held_d = e.d; held_bo = e.bo; held_v = e.v; held_z = e.z;
        end else begin
          chk("no_done", 32'(DONE), 32'd0);
          chk("d_hold", 32'(D), 32'(held_d));
          chk("flags_hold", {29'd0, BO, V, Z}, {29'd0, held_bo, held_v, held_z});
        end
      end
    end
  end

  logic [WIDTH-1:0] edge_vals[8];

  initial begin
    edge_vals = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFF, 16'hFFFE, 16'h7FFE};
    RST = 1'b1; START = 1'b1; A = '0; B = '0; BI = 1'b0;
    rst_at[1] = 1'b1;
    next_free = 2;
    @(posedge CLK);
    #1;

    step(1'b0, 1'b1, 16'h1234, 16'h0234, 1'b0); idle(5);
    step(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0); idle(5);
    step(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0); idle(5);
    step(1'b0, 1'b1, 16'h7FFF, 16'hFFFF, 1'b0); idle(5);
    step(1'b0, 1'b1, 16'h5A5A, 16'h5A59, 1'b1); idle(5);

    // START held high with operands changing every cycle
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    idle(6);

    // Reset during the second busy cycle, then a fresh operation
    step(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h0003, 16'h0001, 1'b0);
    idle(6);

    for (int i = 0; i < 600; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int sel;
      sel = int'($urandom_range(0, 3));
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (sel == 1) b = a;
      if (sel == 2) begin
        a = edge_vals[$urandom_range(0, 7)];
        b = edge_vals[$urandom_range(0, 7)];
      end
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), a, b, 1'($urandom));
    end

    idle(8);
    chk("drain", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
